// File: rtl/receptor_serie_nibble.sv
// Serial-to-parallel word receiver with one-word holding buffer and valid/ready output.
// Optional even-parity framing enabled by defining RECEPTOR_PARIDAD_EN.
module receptor_serie_nibble #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_bit,
    input  logic                           i_bit_valid,
    input  logic                           i_clear,
    input  logic                           i_ready,
    output logic [WIDTH-1:0]               o_data,
    output logic                           o_valid,
    output logic                           o_overflow,
    output logic [$clog2(WIDTH+1)-1:0]     o_bit_count,
    output logic                           o_parity_err
);
    localparam int CW = $clog2(WIDTH+1);
`ifdef RECEPTOR_PARIDAD_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    count;
    logic [CW-1:0]    idx;
    logic             capture;
    logic             done;
    logic             xfer;
    logic             perr;

    assign o_bit_count = count;

    // word is the shift register with this cycle's bit already merged in, so a
    // completing capture can load the full word on the same edge.
    always_comb begin
        capture = i_bit_valid && !i_clear;
        done    = capture && (count == CW'(FRAME-1));
        xfer    = o_valid && i_ready;
        idx     = LSB_FIRST ? count : (CW'(WIDTH-1) - count);
        word    = sr;
        for (int b = 0; b < WIDTH; b++) begin
            if (capture && (count < CW'(WIDTH)) && (idx == CW'(b)))
                word[b] = i_bit;
        end
`ifdef RECEPTOR_PARIDAD_EN
        perr = (^sr) ^ i_bit;
`else
        perr = 1'b0;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= COLLECT;
            sr           <= '0;
            count        <= '0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_overflow   <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            if (i_clear) begin
                count <= '0;
            end else if (i_bit_valid) begin
                sr    <= word;
                count <= done ? '0 : count + CW'(1);
            end

            case (state)
                COLLECT: begin
                    if (done) begin
                        o_data       <= word;
                        o_parity_err <= perr;
                        o_valid      <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (done) begin
                        if (xfer) begin
                            o_data       <= word;
                            o_parity_err <= perr;
                        end else begin
                            o_overflow   <= 1'b1;
                        end
                    end else if (xfer) begin
                        o_valid <= 1'b0;
                        state   <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_receptor_serie_nibble.sv
// Directed bench: two receivers (LSB-first and MSB-first) fed the same serial stream.
module tb_receptor_serie_nibble;
    logic       clk = 1'b0;
    logic       rst_n, bit_in, bit_valid, clear, ready;
    logic [3:0] da, db;
    logic       va, vb, ova, ovb, pa, pb;
    logic [2:0] ca, cb;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    receptor_serie_nibble #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_bit(bit_in), .i_bit_valid(bit_valid),
        .i_clear(clear), .i_ready(ready), .o_data(da), .o_valid(va),
        .o_overflow(ova), .o_bit_count(ca), .o_parity_err(pa));

    receptor_serie_nibble #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_bit(bit_in), .i_bit_valid(bit_valid),
        .i_clear(clear), .i_ready(ready), .o_data(db), .o_valid(vb),
        .o_overflow(ovb), .o_bit_count(cb), .o_parity_err(pb));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Drive inputs just after an edge, then advance to 1 time unit past the next edge.
    task automatic step(input logic b, input logic v, input logic c);
        bit_in = b; bit_valid = v; clear = c;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 1'b1, 1'b0);
        chk("rst_data", da, 4'h0);
        chk("rst_valid", va, 1'b0);
        chk("rst_ovf", ova, 1'b0);
        chk("rst_count", ca, 3'd0);
        chk("rst_perr", pa, 1'b0);
        rst_n = 1'b1;

`ifdef RECEPTOR_PARIDAD_EN
        step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        chk("par_count4", ca, 3'd4);
        chk("par_novalid", va, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("par_valid", va, 1'b1);
        chk("par_data_a", da, 4'b1101);
        chk("par_data_b", db, 4'b1011);
        chk("par_ok", pa, 1'b0);
        chk("par_count0", ca, 3'd0);
        step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("par_valid2", va, 1'b1);
        chk("par_err_a", pa, 1'b1);
        chk("par_err_b", pb, 1'b1);
        chk("par_data2", da, 4'b1101);
`else
        // Basic word, ready high: 1,0,1,1
        step(1'b1, 1'b1, 1'b0); chk("cnt1", ca, 3'd1);
        step(1'b0, 1'b1, 1'b0); chk("cnt2", ca, 3'd2);
        step(1'b1, 1'b1, 1'b0); chk("cnt3", ca, 3'd3);
        chk("novalid_early", va, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("cnt_wrap", ca, 3'd0);
        chk("valid_a", va, 1'b1);
        chk("data_lsb", da, 4'b1101);
        chk("data_msb", db, 4'b1011);
        chk("perr_off", pa, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("valid_pulse", va, 1'b0);

        // Overflow: ready low across two words 0,0,1,1 then 1,1,1,1
        ready = 1'b0;
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        chk("ovf_valid1", va, 1'b1);
        chk("ovf_data1", da, 4'b1100);
        chk("ovf_clear1", ova, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        chk("ovf_set", ova, 1'b1);
        chk("ovf_hold_data", da, 4'b1100);
        chk("ovf_hold_valid", va, 1'b1);
        ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("ovf_xfer", va, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("ovf_idle", va, 1'b0);
        chk("ovf_sticky", ova, 1'b1);

        // Completion on the same edge as a transfer
        rst_n = 1'b0; step(1'b0, 1'b0, 1'b0); rst_n = 1'b1;
        chk("rst2_ovf", ova, 1'b0);
        ready = 1'b0;
        step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
        chk("same_first", da, 4'b0001);
        step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("same_hold", da, 4'b0001);
        ready = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        chk("same_valid", va, 1'b1);
        chk("same_data", da, 4'b0110);
        chk("same_noovf", ova, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("same_drain", va, 1'b0);

        // Clear mid-word, then a clean word 0,1,0,0
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        chk("clr_pre", ca, 3'd2);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_count", ca, 3'd0);
        chk("clr_novalid", va, 1'b0);
        step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
        chk("clr_valid", va, 1'b1);
        chk("clr_data", da, 4'b0010);
        chk("clr_data_b", db, 4'b0100);
        step(1'b0, 1'b0, 1'b0);

        // Reset mid-word
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        chk("mid_count", ca, 3'd3);
        rst_n = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        chk("mid_rst_count", ca, 3'd0);
        chk("mid_rst_data", da, 4'h0);
        chk("mid_rst_valid", va, 1'b0);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        chk("post_rst_count", ca, 3'd1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
